// File: rtl/eth_frame_receiver.sv
// Ethernet frame receiver: header capture, payload stream with FCS stripped, CRC-32/length check.
// Optional ADDR_FILTER_EN: silently drop frames not addressed to LOCAL_MAC or broadcast.
module eth_frame_receiver #(
  parameter int          MAX_PAYLOAD = 1500,
  parameter logic [47:0] LOCAL_MAC   = 48'hAABBCCDDEEFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [47:0] dest_mac,
  output logic [47:0] src_mac,
  output logic [15:0] ethertype,
  output logic        hdr_valid,
  output logic [7:0]  pl_data,
  output logic        pl_valid,
  output logic        pl_last,
  output logic        frame_done,
  output logic        crc_err,
  output logic        len_err
);

  typedef enum logic [2:0] {S_RESYNC, S_IDLE, S_HDR, S_PAYLOAD, S_DROP} state_t;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [16:0] OVERSIZE_LIM = 17'(MAX_PAYLOAD + 18);

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction

  state_t        state, state_nxt;
  logic [15:0]   byte_cnt;
  logic [15:0]   cnt_inc;
  logic [31:0]   crc;
  logic [31:0]   crc_nxt;
  logic [103:0]  hdr_sr;
  logic [111:0]  hdr_full;
  logic [7:0]    dly [5];
  logic [2:0]    dly_cnt;
  logic          dly_full;
  logic          hdr_last;
  logic          oversize;
  logic          len_bad;
  logic          addr_ok;
  logic          drop_report;

  assign cnt_inc  = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
  assign crc_nxt  = crc_step(crc, rx_data);
  assign hdr_full = {hdr_sr, rx_data};
  assign dly_full = (dly_cnt == 3'd5);
  assign hdr_last = (byte_cnt == 16'd13);
  assign oversize = ({1'b0, cnt_inc} > OVERSIZE_LIM);
  assign len_bad  = (byte_cnt < 16'd18);

`ifdef ADDR_FILTER_EN
  assign addr_ok = (hdr_full[111:64] == LOCAL_MAC) || (hdr_full[111:64] == 48'hFFFF_FFFF_FFFF);
`else
  // Every address is accepted; the compare only keeps LOCAL_MAC referenced.
  assign addr_ok = 1'b1 | (hdr_full[111:64] == LOCAL_MAC);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_RESYNC;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RESYNC:  if (!rx_valid) state_nxt = S_IDLE;
      S_IDLE:    if (rx_valid)  state_nxt = S_HDR;
      S_HDR: begin
        if (!rx_valid)    state_nxt = S_IDLE;
        else if (hdr_last) state_nxt = addr_ok ? S_PAYLOAD : S_DROP;
      end
      S_PAYLOAD: begin
        if (!rx_valid)    state_nxt = S_IDLE;
        else if (oversize) state_nxt = S_DROP;
      end
      S_DROP:    if (!rx_valid) state_nxt = S_IDLE;
      default:   state_nxt = S_RESYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dest_mac    <= '0;
      src_mac     <= '0;
      ethertype   <= '0;
      hdr_valid   <= 1'b0;
      pl_data     <= '0;
      pl_valid    <= 1'b0;
      pl_last     <= 1'b0;
      frame_done  <= 1'b0;
      crc_err     <= 1'b0;
      len_err     <= 1'b0;
      byte_cnt    <= '0;
      crc         <= CRC_INIT;
      hdr_sr      <= '0;
      dly_cnt     <= '0;
      drop_report <= 1'b0;
      for (int i = 0; i < 5; i++) dly[i] <= '0;
    end else begin
      hdr_valid  <= 1'b0;
      pl_valid   <= 1'b0;
      pl_last    <= 1'b0;
      frame_done <= 1'b0;
      crc_err    <= 1'b0;
      len_err    <= 1'b0;
      // Any gap re-arms per-frame state, whatever the FSM was doing.
      if (!rx_valid) begin
        byte_cnt <= '0;
        crc      <= CRC_INIT;
        dly_cnt  <= '0;
      end
      case (state)
        S_IDLE, S_HDR: begin
          if (rx_valid) begin
            byte_cnt <= cnt_inc;
            crc      <= crc_nxt;
            hdr_sr   <= hdr_full[103:0];
            if (state == S_HDR && hdr_last) begin
              if (addr_ok) begin
                hdr_valid <= 1'b1;
                dest_mac  <= hdr_full[111:64];
                src_mac   <= hdr_full[63:16];
                ethertype <= hdr_full[15:0];
              end else begin
                drop_report <= 1'b0;
              end
            end
          end else if (state == S_HDR) begin
            frame_done <= 1'b1;
            len_err    <= 1'b1;
          end
        end
        S_PAYLOAD: begin
          if (rx_valid) begin
            byte_cnt <= cnt_inc;
            crc      <= crc_nxt;
            if (oversize) begin
              drop_report <= 1'b1;
            end else begin
              dly[0] <= rx_data;
              for (int i = 1; i < 5; i++) dly[i] <= dly[i-1];
              if (dly_full) begin
                pl_data  <= dly[4];
                pl_valid <= 1'b1;
              end else begin
                dly_cnt <= dly_cnt + 3'd1;
              end
            end
          end else begin
            frame_done <= 1'b1;
            len_err    <= len_bad;
            crc_err    <= !len_bad && (crc != CRC_RESIDUE);
            // With a full buffer the oldest byte is the last payload byte; the rest is FCS.
            if (dly_full) begin
              pl_data  <= dly[4];
              pl_valid <= 1'b1;
              pl_last  <= 1'b1;
            end
          end
        end
        S_DROP: begin
          if (!rx_valid && drop_report) begin
            frame_done <= 1'b1;
            len_err    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_frame_receiver.sv
// Directed bench for eth_frame_receiver: good/bad CRC, runts, length boundaries, oversize, mid-frame reset.
module tb_eth_frame_receiver;
  localparam int MAXP = 16;
  localparam logic [47:0] DA = 48'hAABBCCDDEEFF;
  localparam logic [47:0] SA = 48'h112233445566;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [47:0] dest_mac, src_mac;
  logic [15:0] ethertype;
  logic        hdr_valid, pl_valid, pl_last, frame_done, crc_err, len_err;
  logic [7:0]  pl_data;

  eth_frame_receiver #(.MAX_PAYLOAD(MAXP)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .dest_mac(dest_mac), .src_mac(src_mac), .ethertype(ethertype), .hdr_valid(hdr_valid),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_last(pl_last),
    .frame_done(frame_done), .crc_err(crc_err), .len_err(len_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int         hdr_n = 0, last_n = 0, stray_n = 0, pl_since = 0;
  int         h0, l0;
  logic [7:0] last_dat;
  logic [7:0] pl_q[$];
  logic [1:0] done_q[$];
  int         plcnt_q[$];
  logic [7:0] frm[$];
  logic [7:0] pay[$];

  always @(negedge clk) begin
    if (hdr_valid) hdr_n++;
    if (pl_valid) begin
      pl_q.push_back(pl_data);
      pl_since++;
    end
    if (pl_last) begin
      if (pl_valid) begin
        last_n++;
        last_dat = pl_data;
      end else stray_n++;
    end
    if (frame_done) begin
      done_q.push_back({crc_err, len_err});
      plcnt_q.push_back(pl_since);
      pl_since = 0;
    end
  end

  function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic set_good_pay();
    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
  endtask

  task automatic set_ramp_pay(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'(i * 7 + 1));
  endtask

  task automatic mk_frame(input logic [47:0] da, input logic [47:0] sa, input logic [15:0] et, input bit add_fcs);
    logic [31:0] c;
    frm.delete();
    for (int i = 5; i >= 0; i--) frm.push_back(da[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) frm.push_back(sa[i*8 +: 8]);
    frm.push_back(et[15:8]);
    frm.push_back(et[7:0]);
    foreach (pay[i]) frm.push_back(pay[i]);
    if (add_fcs) begin
      c = 32'hFFFFFFFF;
      foreach (frm[i]) c = crc_ref(c, frm[i]);
      c = ~c;
      for (int i = 0; i < 4; i++) frm.push_back(c[i*8 +: 8]);
    end
  endtask

  task automatic clear_mon();
    pl_q.delete();
    done_q.delete();
    plcnt_q.delete();
    pl_since = 0;
    h0 = hdr_n;
    l0 = last_n;
  endtask

  task automatic send(input int rst_at, input int gap);
    foreach (frm[i]) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = frm[i];
      rst      = (i == rst_at);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = '0;
    rst      = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic chk_stream(input string tag);
    chk({tag, "_cnt"}, pl_q.size(), pay.size());
    for (int i = 0; i < pay.size() && i < pl_q.size(); i++) chk(tag, pl_q[i], pay[i]);
  endtask

  task automatic chk_done(input string tag, input int idx, input bit exp_crc, input bit exp_len);
    if (done_q.size() > idx) begin
      chk({tag, "_crc_err"}, done_q[idx][1], exp_crc);
      chk({tag, "_len_err"}, done_q[idx][0], exp_len);
    end else chk({tag, "_done_seen"}, 0, 1);
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0;
    repeat (4) @(negedge clk);
    chk("rst_dest", dest_mac, 0);
    chk("rst_src", src_mac, 0);
    chk("rst_type", ethertype, 0);
    chk("rst_hdr_valid", hdr_valid, 0);
    chk("rst_pl_valid", pl_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_errs", {crc_err, len_err}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Good frame
    set_good_pay(); mk_frame(DA, SA, 16'h0800, 1'b1); clear_mon(); send(-1, 4);
    chk("good_hdr_n", hdr_n - h0, 1);
    chk("good_dest", dest_mac, DA);
    chk("good_src", src_mac, SA);
    chk("good_type", ethertype, 16'h0800);
    chk_stream("good_pl");
    chk("good_last_n", last_n - l0, 1);
    chk("good_last_dat", last_dat, 8'hBC);
    chk("good_done_n", done_q.size(), 1);
    chk_done("good", 0, 1'b0, 1'b0);

    // Corrupted payload byte 3, FCS left as computed for the original
    set_good_pay(); mk_frame(DA, SA, 16'h0800, 1'b1);
    frm[17] = 8'hEE; pay[3] = 8'hEE;
    clear_mon(); send(-1, 4);
    chk_stream("badcrc_pl");
    chk_done("badcrc", 0, 1'b1, 1'b0);

    // 12-byte runt
    pay.delete(); mk_frame(DA, SA, 16'h0800, 1'b0);
    void'(frm.pop_back()); void'(frm.pop_back());
    clear_mon(); send(-1, 4);
    chk("runt12_hdr_n", hdr_n - h0, 0);
    chk("runt12_pl_cnt", pl_q.size(), 0);
    chk("runt12_done_n", done_q.size(), 1);
    chk_done("runt12", 0, 1'b0, 1'b1);

    // 17-byte runt (one short of minimum)
    pay.delete(); mk_frame(DA, SA, 16'h0800, 1'b1);
    void'(frm.pop_back());
    clear_mon(); send(-1, 4);
    chk("runt17_pl_cnt", pl_q.size(), 0);
    chk_done("runt17", 0, 1'b0, 1'b1);

    // 18 bytes: zero payload, good CRC
    pay.delete(); mk_frame(DA, SA, 16'h88B5, 1'b1); clear_mon(); send(-1, 4);
    chk("zero_hdr_n", hdr_n - h0, 1);
    chk("zero_type", ethertype, 16'h88B5);
    chk("zero_pl_cnt", pl_q.size(), 0);
    chk_done("zero", 0, 1'b0, 1'b0);

    // Payload exactly MAX_PAYLOAD
    set_ramp_pay(MAXP); mk_frame(DA, SA, 16'h0800, 1'b1); clear_mon(); send(-1, 4);
    chk_stream("max_pl");
    chk("max_last_n", last_n - l0, 1);
    chk_done("max", 0, 1'b0, 1'b0);

    // Oversize (20 payload bytes) then a good frame after a single idle cycle
    set_ramp_pay(20); mk_frame(DA, SA, 16'h0800, 1'b1); clear_mon(); send(-1, 1);
    set_good_pay(); mk_frame(SA, DA, 16'h86DD, 1'b1); send(-1, 4);
    chk("ovs_done_n", done_q.size(), 2);
    chk_done("ovs", 0, 1'b0, 1'b1);
    chk_done("after_ovs", 1, 1'b0, 1'b0);
    if (plcnt_q.size() == 2) begin
      chk("ovs_pl_within_max", plcnt_q[0] <= MAXP, 1);
      chk("after_ovs_pl_cnt", plcnt_q[1], 10);
    end else chk("ovs_plcnt_entries", plcnt_q.size(), 2);
    chk("ovs_last_n", last_n - l0, 1);
    if (pl_q.size() >= 10)
      for (int i = 0; i < 10; i++) chk("after_ovs_pl", pl_q[pl_q.size() - 10 + i], pay[i]);
    chk("after_ovs_dest", dest_mac, SA);
    chk("after_ovs_type", ethertype, 16'h86DD);

    // Reset pulse on payload byte 5, stream continues for 20 more bytes
    set_ramp_pay(26); mk_frame(DA, SA, 16'h0800, 1'b0); clear_mon(); send(19, 4);
    chk("rstmid_done_n", done_q.size(), 0);
    chk("rstmid_pl_cnt", pl_q.size(), 0);
    chk("rstmid_dest", dest_mac, 0);
    chk("rstmid_src", src_mac, 0);
    set_good_pay(); mk_frame(DA, SA, 16'h0800, 1'b1); clear_mon(); send(-1, 4);
    chk("after_rst_hdr_n", hdr_n - h0, 1);
    chk_stream("after_rst_pl");
    chk_done("after_rst", 0, 1'b0, 1'b0);

`ifdef ADDR_FILTER_EN
    set_good_pay(); mk_frame(48'h010203040506, SA, 16'h0800, 1'b1); clear_mon(); send(-1, 4);
    chk("filt_hdr_n", hdr_n - h0, 0);
    chk("filt_pl_cnt", pl_q.size(), 0);
    chk("filt_done_n", done_q.size(), 0);
    mk_frame(48'hFFFFFFFFFFFF, SA, 16'h0800, 1'b1); clear_mon(); send(-1, 4);
    chk("bcast_hdr_n", hdr_n - h0, 1);
    chk("bcast_dest", dest_mac, 48'hFFFFFFFFFFFF);
    chk_stream("bcast_pl");
    chk_done("bcast", 0, 1'b0, 1'b0);
`else
    set_good_pay(); mk_frame(48'h010203040506, SA, 16'h0800, 1'b1); clear_mon(); send(-1, 4);
    chk("other_da_hdr_n", hdr_n - h0, 1);
    chk("other_da_dest", dest_mac, 48'h010203040506);
    chk_stream("other_da_pl");
    chk_done("other_da", 0, 1'b0, 1'b0);
`endif

    chk("stray_pl_last", stray_n, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/eth_frame_receiver.md
Name: eth_frame_receiver

Overview:
Byte-stream Ethernet frame receiver and the receive-side counterpart of master_transmitter. It accepts the frame bytes the transmitter emits (destination MAC through FCS, no preamble/SFD) and captures the header fields. It forwards the payload as a stream with a last-byte marker, strips the 4-byte FCS, and checks CRC-32 and length. It sits between the MAC byte interface and the upper-layer payload consumer.

Parameters:
MAX_PAYLOAD, 1500, maximum payload bytes accepted before the frame is declared oversize.
LOCAL_MAC, 48'hAABBCCDDEEFF, station address used only when ADDR_FILTER_EN is defined.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, synchronous, active-high.
rx_data  in  8  frame byte.
rx_valid  in  1  byte strobe; a frame is a contiguous run of rx_valid=1 cycles, ended by the first rx_valid=0 cycle.
dest_mac  out  48  captured destination MAC; byte 0 in [47:40].
src_mac  out  48  captured source MAC; byte 0 in [47:40].
ethertype  out  16  captured EtherType/length; first byte in [15:8].
hdr_valid  out  1  one-cycle pulse, header fields updated.
pl_data  out  8  payload byte.
pl_valid  out  1  pl_data qualifier.
pl_last  out  1  marks the final payload byte; only asserted together with pl_valid.
frame_done  out  1  one-cycle pulse at frame end.
crc_err  out  1  valid with frame_done: FCS mismatch.
len_err  out  1  valid with frame_done: runt (<18 bytes) or oversize frame.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: all outputs 0. Internal state is RESYNC, CRC register 32'hFFFFFFFF, byte count 0, 5-entry delay buffer empty.
- States:
  - RESYNC: wait for a cycle with rx_valid=0, then go to IDLE. Bytes seen here are discarded, with no frame_done. This state covers reset asserted mid-frame.
  - IDLE: rx_valid=1 loads the first byte and goes to HDR.
  - HDR: bytes 0-13 are captured into dest_mac/src_mac/ethertype. hdr_valid pulses the cycle after byte 13 is accepted. Then go to PAYLOAD.
  - PAYLOAD: each byte enters a 5-byte delay buffer. When the buffer is full, each new byte pushes the oldest one out as a registered pl_data/pl_valid in the next cycle. The 4 youngest bytes are always FCS candidates.
  - DROP: consume bytes until rx_valid=0, with no payload output.
- Frame end (rx_valid=0 in HDR or PAYLOAD):
  - In the next cycle, frame_done=1 with crc_err and len_err.
  - If the buffer holds 5 bytes, the oldest is emitted in the same cycle with pl_valid=1 and pl_last=1. The remaining 4 bytes are the FCS and are discarded.
  - Then return to IDLE. One idle cycle between frames is sufficient.
- Length rules:
  - Total bytes < 18: len_err=1, crc_err=0. No payload was emitted.
  - Exactly 18 bytes (zero payload): no pl_valid; frame_done only.
  - Payload bytes exceed MAX_PAYLOAD (total > MAX_PAYLOAD+18): go to DROP, and pl_valid stays 0 from then on. At end, frame_done=1, len_err=1, crc_err=0 with no pl_last. The consumer discards the partial payload.
- CRC:
  - IEEE 802.3 CRC-32, reflected polynomial 32'hEDB88320, init all-ones, one byte per cycle, LSB first.
  - The CRC runs over every byte including the FCS. A good frame leaves residue 32'hDEBB20E3; any other value sets crc_err=1.
  - The FCS arrives least-significant byte first.
- Byte counter: 16-bit, saturating at 16'hFFFF.
- Pad bytes are not stripped. The EtherType value is not interpreted.
- Outputs dest_mac, src_mac and ethertype hold until the next hdr_valid.
- Latency: payload byte k appears 5 accepted bytes later. The final payload byte appears 1 cycle after rx_valid falls.

Optional Feature:
ADDR_FILTER_EN:
- Defined: after byte 13, if dest_mac is neither LOCAL_MAC nor 48'hFFFFFFFFFFFF, go to DROP silently. There is no hdr_valid, no pl_valid and no frame_done for that frame.
- Undefined: every frame is delivered regardless of address, and LOCAL_MAC is unused.

Test Plan:
- Good frame, DA AA:BB:CC:DD:EE:FF, SA 11:22:33:44:55:66, type 0800, payload DE AD BE EF 12 34 56 78 9A BC, correct FCS from the bench's reflected CRC-32 model -> hdr_valid once with those field values; 10 pl_valid bytes in order with pl_last on BC; frame_done with crc_err=0, len_err=0.
- Same frame with payload byte 3 changed EF->EE -> identical payload stream; frame_done with crc_err=1.
- 12-byte runt -> no hdr_valid pulse (only 12 header bytes arrive); frame_done with len_err=1; no pl_valid.
- MAX_PAYLOAD=16, 20-byte payload -> pl_valid never asserted for bytes beyond the 16th; frame_done with len_err=1; next good frame received correctly after one idle cycle.
- rst asserted for 1 cycle at payload byte 5 while rx_valid stays high for 20 more bytes -> no outputs for that frame, no frame_done; following good frame received correctly.
- ADDR_FILTER_EN defined, DA 01:02:03:04:05:06 then DA FF:FF:FF:FF:FF:FF -> first frame produces no output at all; second frame is delivered normally.
